pipe_mem_queue: RTL and testbench
=================================

Name: pipe_mem_queue

Overview:
- Parametrised MEM stage that holds up to DEPTH instructions in flight between EX and WB.
- EX can issue further data_sram requests before earlier loads return data_ok.
- Returned data is matched in order to the oldest waiting entry, then load-extended. Results retire to WB in program order.
- A flush from WB drops all entries and silently discards responses to requests that were already issued.

Parameters:
- DEPTH, 4, maximum instructions held. Power of 2, at least 2.
- PTR_W, $clog2(DEPTH), queue pointer width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EX offers an instruction
- in_allowin  out  1  stage accepts an instruction this cycle
- in_pc  in  32  instruction PC
- in_load_op  in  5  one-hot load type {ld.b, ld.bu, ld.h, ld.hu, ld.w}
- in_alu_result  in  32  ALU result or memory address
- in_rf_we  in  1  register write enable
- in_rf_waddr  in  5  destination register
- in_res_from_mem  in  1  write-back value comes from memory
- in_req  in  1  a data_sram request was accepted for this instruction
- in_ex  in  1  instruction carries an exception
- data_sram_data_ok  in  1  one in-order response this cycle
- data_sram_rdata  in  32  response data
- flush  in  1  WB exception, ertn or tlb flush
- out_valid  out  1  head entry is ready to retire
- out_allowin  in  1  WB accepts
- out_pc  out  32  PC of head entry
- out_rf_we  out  1  out_valid && head rf_we
- out_rf_waddr  out  5  destination register of head entry
- out_rf_wdata  out  32  write-back data of head entry
- out_ex  out  1  out_valid && head ex
- mem_waiting  out  1  some held entry still awaits data
- count  out  PTR_W+1  number of held entries

Behaviour:
- Reset (asynchronous): count=0, all entry valid/done bits=0, head/tail pointers=0, discard_cnt=0.
- Outputs after reset: out_valid=0, out_rf_we=0, out_ex=0, mem_waiting=0, in_allowin=1. Data outputs are 0.
- Entry fields: pc, load_op, alu_result, rf_we, rf_waddr, res_from_mem, req, ex, done, rdata[31:0].
- pop = out_valid && out_allowin && !flush.
- push = in_valid && in_allowin && !flush.
- in_allowin = (count < DEPTH) || pop.
- When full, push and pop in the same cycle is legal; count is unchanged.
- A push writes the entry at tail with done=0. Tail wraps modulo DEPTH.
- Response target = oldest valid entry with req && !done, found by priority search from head.
- Each data_sram_data_ok goes to exactly one destination:
  - if discard_cnt != 0, discard_cnt decrements and data is dropped;
  - else if a target exists, the target gets done=1 and rdata captured;
  - else the response is a protocol error and is ignored.
- Head ready = head valid && (!req || done || (head is target && data_ok && discard_cnt==0)).
- out_valid = head ready && !flush.
- Response bypass: when the head completes in the same cycle data_ok arrives, it uses data_sram_rdata live. Zero-cycle latency from data_ok to out_valid.
- Load extension uses alu_result[1:0] to select the byte or halfword (halfword at offset 0 or 2).
  - ld.b: sign-extend the byte. ld.bu: zero-extend the byte.
  - ld.h: sign-extend the halfword. ld.hu: zero-extend the halfword.
  - ld.w: full word.
- out_rf_wdata = res_from_mem ? extended data : alu_result.
- A non-memory entry behind a waiting load waits; there is no out-of-order retire.
- mem_waiting = OR over valid entries of (req && !done).
- Flush cycle:
  - all entries are invalidated, count becomes 0, head=tail=0;
  - the input is not captured;
  - discard_cnt_next = discard_cnt + (number of valid entries with req && !done) + (in_valid && in_req) − (data_ok ? 1 : 0).
- discard_cnt is PTR_W+2 bits wide and never underflows.
- After a flush, new pushes are accepted immediately. Their responses are matched only once discard_cnt reaches 0.
- An entry with ex=1 and req=0 retires without waiting. An entry with ex=1 and req=1 still waits for its response.

Test Plan:
1. DEPTH=4. Push ld.w with addr 0x1000 and req=1. data_ok with rdata=0xA5A5_1234 arrives 3 cycles later → out_valid in that same cycle, out_rf_wdata=0xA5A5_1234, then count=0.
2. Push ld.b addr 0x..3, ld.hu addr 0x..2, ld.w back to back, all req=1. Then 3 data_ok with rdata=0x80FF_7F01 → outputs 0xFFFF_FF80, 0x0000_80FF, 0x80FF_7F01, in order.
3. Hold out_allowin=0 and push 4 non-memory entries → count=4, in_allowin=0. On the cycle out_allowin=1, push and pop together → count stays 4.
4. Push ld.w (req=1) then add (req=0, alu_result=7) → the add is not retired until the load's data_ok. Retire order is load then add.
5. Push 2 loads (req=1), then flush with in_valid && in_req → count=0, discard_cnt=3. The next 3 data_ok are dropped. A new load pushed afterwards receives the 4th response.
6. Assert reset while 2 loads are pending → next cycle count=0, out_valid=0, mem_waiting=0, in_allowin=1, discard_cnt=0.

Source files
------------

// File: rtl/pipe_mem_queue_if.sv
// EX/MEM/WB connection bundle for the MEM-stage queue: issue side, data_sram
// response side, flush and retire side.
interface pipe_mem_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_allowin;
   logic [31:0]      in_pc;
   logic [4:0]       in_load_op;
   logic [31:0]      in_alu_result;
   logic             in_rf_we;
   logic [4:0]       in_rf_waddr;
   logic             in_res_from_mem;
   logic             in_req;
   logic             in_ex;
   logic             data_sram_data_ok;
   logic [31:0]      data_sram_rdata;
   logic             flush;
   logic             out_valid;
   logic             out_allowin;
   logic [31:0]      out_pc;
   logic             out_rf_we;
   logic [4:0]       out_rf_waddr;
   logic [31:0]      out_rf_wdata;
   logic             out_ex;
   logic             mem_waiting;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_pc, in_load_op, in_alu_result, in_rf_we, in_rf_waddr,
             in_res_from_mem, in_req, in_ex, data_sram_data_ok, data_sram_rdata,
             flush, out_allowin,
      input  in_allowin, out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata,
             out_ex, mem_waiting, count
   );

   modport slave (
      input  in_valid, in_pc, in_load_op, in_alu_result, in_rf_we, in_rf_waddr,
             in_res_from_mem, in_req, in_ex, data_sram_data_ok, data_sram_rdata,
             flush, out_allowin,
      output in_allowin, out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata,
             out_ex, mem_waiting, count
   );
endinterface

// File: rtl/pipe_mem_queue.sv
// MEM stage holding up to DEPTH in-flight instructions; in-order data_sram
// responses fill the oldest waiting entry and results retire in program order.
module pipe_mem_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input logic             clk,
   input logic             reset,
   pipe_mem_queue_if.slave bus
);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned DC_W  = PTR_W + 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  load_op;
      logic [31:0] alu_result;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic        res_from_mem;
      logic        req;
      logic        ex;
      logic [31:0] rdata;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DC_W-1:0]  disc_q, disc_d, disc_sum;

   logic [DEPTH-1:0] wait_vec;
   logic [CNT_W-1:0] pend_cnt;
   logic             tgt_found;
   logic [PTR_W-1:0] tgt_idx, idx;
   logic             resp_live, head_hit, head_ready, out_valid_c;
   logic             pop, push, allowin;
   entry_t           head_e;
   logic [31:0]      ld_data, ext_data;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;

   // Entries that issued a request and still await its response
   always_comb begin
      wait_vec = '0;
      pend_cnt = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         wait_vec[i] = valid_q[i] & ent_q[i].req & ~done_q[i];
         pend_cnt    = pend_cnt + CNT_W'(wait_vec[i]);
      end
   end

   // Oldest waiting entry, searched from head in age order
   always_comb begin
      tgt_found = 1'b0;
      tgt_idx   = head_q;
      idx       = head_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (!tgt_found && wait_vec[idx]) begin
            tgt_found = 1'b1;
            tgt_idx   = idx;
         end
      end
   end

   always_comb begin
      head_e      = ent_q[head_q];
      resp_live   = bus.data_sram_data_ok && (disc_q == '0);
      head_hit    = tgt_found && (tgt_idx == head_q) && resp_live;
      head_ready  = valid_q[head_q] && (!head_e.req || done_q[head_q] || head_hit);
      out_valid_c = head_ready && !bus.flush;
      pop         = out_valid_c && bus.out_allowin;
      allowin     = (count_q < CNT_W'(DEPTH)) || pop;
      push        = bus.in_valid && allowin && !bus.flush;
   end

   // Load extension; a head completing this cycle takes the response live
   always_comb begin
      ld_data = done_q[head_q] ? head_e.rdata : bus.data_sram_rdata;
      case (head_e.alu_result[1:0])
         2'd0:    byte_sel = ld_data[7:0];
         2'd1:    byte_sel = ld_data[15:8];
         2'd2:    byte_sel = ld_data[23:16];
         default: byte_sel = ld_data[31:24];
      endcase
      half_sel = head_e.alu_result[1] ? ld_data[31:16] : ld_data[15:0];
      ext_data = ld_data;
      if (head_e.load_op[4])      ext_data = {{24{byte_sel[7]}}, byte_sel};
      else if (head_e.load_op[3]) ext_data = {24'd0, byte_sel};
      else if (head_e.load_op[2]) ext_data = {{16{half_sel[15]}}, half_sel};
      else if (head_e.load_op[1]) ext_data = {16'd0, half_sel};
   end

   assign bus.in_allowin   = allowin;
   assign bus.out_valid    = out_valid_c;
   assign bus.out_pc       = head_e.pc;
   assign bus.out_rf_we    = out_valid_c && head_e.rf_we;
   assign bus.out_rf_waddr = head_e.rf_waddr;
   assign bus.out_rf_wdata = head_e.res_from_mem ? ext_data : head_e.alu_result;
   assign bus.out_ex       = out_valid_c && head_e.ex;
   assign bus.mem_waiting  = |wait_vec;
   assign bus.count        = count_q;

   always_comb begin
      ent_d    = ent_q;
      valid_d  = valid_q;
      done_d   = done_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      disc_d   = disc_q;
      disc_sum = '0;
      if (bus.flush) begin
         // Everything still owed to us, old or just issued, must be swallowed
         valid_d  = '0;
         head_d   = '0;
         tail_d   = '0;
         count_d  = '0;
         disc_sum = disc_q + DC_W'(pend_cnt) + DC_W'(bus.in_valid && bus.in_req);
         disc_d   = (bus.data_sram_data_ok && (disc_sum != '0)) ? disc_sum - DC_W'(1) : disc_sum;
      end else begin
         if (bus.data_sram_data_ok) begin
            if (disc_q != '0) begin
               disc_d = disc_q - DC_W'(1);
            end else if (tgt_found) begin
               done_d[tgt_idx]      = 1'b1;
               ent_d[tgt_idx].rdata = bus.data_sram_rdata;
            end
         end
         if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
         end
         if (push) begin
            ent_d[tail_q].pc           = bus.in_pc;
            ent_d[tail_q].load_op      = bus.in_load_op;
            ent_d[tail_q].alu_result   = bus.in_alu_result;
            ent_d[tail_q].rf_we        = bus.in_rf_we;
            ent_d[tail_q].rf_waddr     = bus.in_rf_waddr;
            ent_d[tail_q].res_from_mem = bus.in_res_from_mem;
            ent_d[tail_q].req          = bus.in_req;
            ent_d[tail_q].ex           = bus.in_ex;
            ent_d[tail_q].rdata        = '0;
            valid_d[tail_q]            = 1'b1;
            done_d[tail_q]             = 1'b0;
            tail_d                     = tail_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         disc_q  <= '0;
      end else begin
         ent_q   <= ent_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         disc_q  <= disc_d;
      end
   end
endmodule

// File: tb/tb_pipe_mem_queue.sv
// Bench for pipe_mem_queue: extension table, directed corner sequences and a
// randomized run, all cross-checked every cycle against a queue-based model.
module tb_pipe_mem_queue;
   localparam int unsigned DEPTH = 4;
   localparam logic [4:0] LD_B  = 5'b10000;
   localparam logic [4:0] LD_BU = 5'b01000;
   localparam logic [4:0] LD_H  = 5'b00100;
   localparam logic [4:0] LD_HU = 5'b00010;
   localparam logic [4:0] LD_W  = 5'b00001;

   logic clk = 1'b0;
   logic reset = 1'b1;

   pipe_mem_queue_if #(.DEPTH(DEPTH)) bus ();
   pipe_mem_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of entries in program order
   typedef struct {
      logic [31:0] pc;
      logic [4:0]  op;
      logic [31:0] alu;
      logic        rf_we;
      logic [4:0]  waddr;
      logic        rfm;
      logic        req;
      logic        ex;
      logic        done;
      logic [31:0] rdata;
   } m_ent_t;

   m_ent_t mq[$];
   int     disc = 0;
   int     m_tgt;
   logic   m_pop, m_push;

   function automatic logic [31:0] ext(input logic [4:0] op, input logic [31:0] addr,
                                       input logic [31:0] d);
      logic [31:0] b, h;
      b = (d >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
      h = (d >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
      case (op)
         LD_B:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
         LD_BU:   return b;
         LD_H:    return h[15] ? (h | 32'hFFFF_0000) : h;
         LD_HU:   return h;
         default: return d;
      endcase
   endfunction

   task automatic model_check();
      logic        hr, ov, allow;
      logic [31:0] d, wd;
      m_tgt = -1;
      foreach (mq[i]) if (m_tgt < 0 && mq[i].req && !mq[i].done) m_tgt = i;
      hr = (mq.size() > 0) &&
           (!mq[0].req || mq[0].done || (m_tgt == 0 && bus.data_sram_data_ok && disc == 0));
      ov     = hr && !bus.flush;
      m_pop  = ov && bus.out_allowin;
      allow  = (mq.size() < DEPTH) || m_pop;
      m_push = bus.in_valid && allow && !bus.flush;
      chk("m_out_valid",   32'(bus.out_valid),   32'(ov));
      chk("m_in_allowin",  32'(bus.in_allowin),  32'(allow));
      chk("m_count",       32'(bus.count),       32'(mq.size()));
      chk("m_mem_waiting", 32'(bus.mem_waiting), 32'(m_tgt >= 0));
      if (ov) begin
         d  = mq[0].done ? mq[0].rdata : bus.data_sram_rdata;
         wd = mq[0].rfm ? ext(mq[0].op, mq[0].alu, d) : mq[0].alu;
         chk("m_out_pc",       bus.out_pc,              mq[0].pc);
         chk("m_out_rf_wdata", bus.out_rf_wdata,        wd);
         chk("m_out_rf_waddr", 32'(bus.out_rf_waddr),   32'(mq[0].waddr));
         chk("m_out_rf_we",    32'(bus.out_rf_we),      32'(mq[0].rf_we));
         chk("m_out_ex",       32'(bus.out_ex),         32'(mq[0].ex));
      end else begin
         chk("m_out_rf_we_idle", 32'(bus.out_rf_we), 32'd0);
         chk("m_out_ex_idle",    32'(bus.out_ex),    32'd0);
      end
   endtask

   task automatic model_update();
      int     pend;
      m_ent_t e;
      if (bus.flush) begin
         pend = 0;
         foreach (mq[i]) if (mq[i].req && !mq[i].done) pend++;
         disc = disc + pend + ((bus.in_valid && bus.in_req) ? 1 : 0);
         if (bus.data_sram_data_ok && disc > 0) disc--;
         mq.delete();
      end else begin
         if (bus.data_sram_data_ok) begin
            if (disc > 0) disc--;
            else if (m_tgt >= 0) begin
               mq[m_tgt].done  = 1'b1;
               mq[m_tgt].rdata = bus.data_sram_rdata;
            end
         end
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            e.pc = bus.in_pc;         e.op = bus.in_load_op;   e.alu = bus.in_alu_result;
            e.rf_we = bus.in_rf_we;   e.waddr = bus.in_rf_waddr;
            e.rfm = bus.in_res_from_mem; e.req = bus.in_req;   e.ex = bus.in_ex;
            e.done = 1'b0;            e.rdata = '0;
            mq.push_back(e);
         end
      end
   endtask

   task automatic pre();
      #1;
      model_check();
   endtask

   task automatic post();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic cycle();
      pre();
      post();
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;      bus.in_pc = '0;        bus.in_load_op = '0;
      bus.in_alu_result = '0;   bus.in_rf_we = 1'b0;   bus.in_rf_waddr = '0;
      bus.in_res_from_mem = 1'b0; bus.in_req = 1'b0;   bus.in_ex = 1'b0;
      bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = '0;
      bus.flush = 1'b0;         bus.out_allowin = 1'b1;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic [4:0] op, input logic [31:0] alu,
                           input logic rfm, input logic req, input logic ex);
      bus.in_valid = 1'b1;        bus.in_pc = pc;          bus.in_load_op = op;
      bus.in_alu_result = alu;    bus.in_rf_we = 1'b1;     bus.in_rf_waddr = pc[6:2];
      bus.in_res_from_mem = rfm;  bus.in_req = req;        bus.in_ex = ex;
   endtask

   task automatic resp(input logic [31:0] d);
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = d;
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] addr;
      logic        rfm;
      logic        req;
      int          lat;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{LD_W,  32'h0000_1000, 1'b1, 1'b1, 2, 32'hA5A5_1234, 32'hA5A5_1234};
      tbl[1] = '{LD_B,  32'h0000_1003, 1'b1, 1'b1, 0, 32'h80FF_7F01, 32'hFFFF_FF80};
      tbl[2] = '{LD_HU, 32'h0000_1002, 1'b1, 1'b1, 1, 32'h80FF_7F01, 32'h0000_80FF};
      tbl[3] = '{LD_W,  32'h0000_1004, 1'b1, 1'b1, 0, 32'h80FF_7F01, 32'h80FF_7F01};
      tbl[4] = '{LD_BU, 32'h0000_1001, 1'b1, 1'b1, 1, 32'h80FF_7F01, 32'h0000_007F};
      tbl[5] = '{LD_H,  32'h0000_1000, 1'b1, 1'b1, 0, 32'h1234_8001, 32'hFFFF_8001};
      tbl[6] = '{LD_B,  32'h0000_1002, 1'b1, 1'b1, 3, 32'h1234_5678, 32'h0000_0034};
      tbl[7] = '{LD_BU, 32'h0000_1000, 1'b1, 1'b1, 0, 32'h0000_00F0, 32'h0000_00F0};
      tbl[8] = '{LD_H,  32'h0000_1002, 1'b1, 1'b1, 0, 32'h7FFF_0000, 32'h0000_7FFF};
      tbl[9] = '{5'd0,  32'h0000_0007, 1'b0, 1'b0, 0, 32'h0,         32'h0000_0007};

      idle();
      @(negedge clk);
      #1;
      chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
      chk("rst_in_allowin",  32'(bus.in_allowin),  32'd1);
      chk("rst_count",       32'(bus.count),       32'd0);
      chk("rst_mem_waiting", 32'(bus.mem_waiting), 32'd0);
      chk("rst_out_rf_we",   32'(bus.out_rf_we),   32'd0);
      chk("rst_out_ex",      32'(bus.out_ex),      32'd0);
      chk("rst_out_wdata",   bus.out_rf_wdata,     32'd0);
      chk("rst_out_pc",      bus.out_pc,           32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single-load table: push, wait, respond, confirm drained
      for (int v = 0; v < 10; v++) begin
         idle();
         set_push(32'h1C00_0000 + 32'(v * 4), tbl[v].op, tbl[v].addr, tbl[v].rfm, tbl[v].req, 1'b0);
         pre(); chk("tbl_allowin", 32'(bus.in_allowin), 32'd1); post();
         for (int k = 0; k < tbl[v].lat; k++) begin
            idle();
            pre(); chk("tbl_wait", 32'(bus.out_valid), 32'd0); post();
         end
         idle();
         if (tbl[v].req) resp(tbl[v].rdata);
         pre();
         chk("tbl_valid", 32'(bus.out_valid), 32'd1);
         chk("tbl_wdata", bus.out_rf_wdata, tbl[v].exp);
         post();
         idle();
         pre(); chk("tbl_count", 32'(bus.count), 32'd0); post();
      end

      // Three loads back to back, three in-order responses
      idle(); set_push(32'h100, LD_B,  32'h0000_2003, 1'b1, 1'b1, 1'b0); cycle();
      idle(); set_push(32'h104, LD_HU, 32'h0000_2002, 1'b1, 1'b1, 1'b0); cycle();
      idle(); set_push(32'h108, LD_W,  32'h0000_2000, 1'b1, 1'b1, 1'b0); cycle();
      idle(); resp(32'h80FF_7F01);
      pre(); chk("b2b_v0", 32'(bus.out_valid), 32'd1); chk("b2b_d0", bus.out_rf_wdata, 32'hFFFF_FF80); post();
      idle(); resp(32'h80FF_7F01);
      pre(); chk("b2b_v1", 32'(bus.out_valid), 32'd1); chk("b2b_d1", bus.out_rf_wdata, 32'h0000_80FF); post();
      idle(); resp(32'h80FF_7F01);
      pre(); chk("b2b_v2", 32'(bus.out_valid), 32'd1); chk("b2b_d2", bus.out_rf_wdata, 32'h80FF_7F01); post();
      idle(); pre(); chk("b2b_count", 32'(bus.count), 32'd0); post();

      // Fill while WB stalls, then simultaneous push and pop when full
      for (int i = 0; i < 4; i++) begin
         idle(); bus.out_allowin = 1'b0;
         set_push(32'h200 + 32'(i * 4), 5'd0, 32'h10 + 32'(i), 1'b0, 1'b0, 1'b0);
         cycle();
      end
      idle(); bus.out_allowin = 1'b0;
      pre();
      chk("full_count",   32'(bus.count),      32'd4);
      chk("full_allowin", 32'(bus.in_allowin), 32'd0);
      post();
      idle(); set_push(32'h300, 5'd0, 32'h99, 1'b0, 1'b0, 1'b0);
      pre();
      chk("full_pp_allowin", 32'(bus.in_allowin), 32'd1);
      chk("full_pp_wdata",   bus.out_rf_wdata,     32'h10);
      post();
      idle(); bus.out_allowin = 1'b0;
      pre(); chk("full_pp_count", 32'(bus.count), 32'd4); post();
      idle(); pre(); chk("drain_0", bus.out_rf_wdata, 32'h11); post();
      idle(); pre(); chk("drain_1", bus.out_rf_wdata, 32'h12); post();
      idle(); pre(); chk("drain_2", bus.out_rf_wdata, 32'h13); post();
      idle(); pre(); chk("drain_3", bus.out_rf_wdata, 32'h99); post();

      // Non-memory op behind a waiting load retires after it
      idle(); set_push(32'h400, LD_W, 32'h0000_3000, 1'b1, 1'b1, 1'b0); cycle();
      idle(); set_push(32'h404, 5'd0, 32'h7, 1'b0, 1'b0, 1'b0); cycle();
      idle(); pre(); chk("order_hold", 32'(bus.out_valid), 32'd0); post();
      idle(); resp(32'h0000_0055);
      pre(); chk("order_ld_pc", bus.out_pc, 32'h400); chk("order_ld_d", bus.out_rf_wdata, 32'h55); post();
      idle();
      pre(); chk("order_add_v", 32'(bus.out_valid), 32'd1); chk("order_add_d", bus.out_rf_wdata, 32'h7); post();

      // Flush with two loads pending plus one issuing: three responses dropped
      idle(); set_push(32'h500, LD_W, 32'h0, 1'b1, 1'b1, 1'b0); cycle();
      idle(); set_push(32'h504, LD_W, 32'h4, 1'b1, 1'b1, 1'b0); cycle();
      idle(); set_push(32'h508, LD_W, 32'h8, 1'b1, 1'b1, 1'b0); bus.flush = 1'b1;
      pre(); chk("flush_ov", 32'(bus.out_valid), 32'd0); post();
      idle(); set_push(32'h600, LD_W, 32'h0, 1'b1, 1'b1, 1'b0);
      pre(); chk("flush_count", 32'(bus.count), 32'd0); post();
      for (int k = 0; k < 3; k++) begin
         idle(); resp(32'h111 * 32'(k + 1));
         pre(); chk("flush_drop", 32'(bus.out_valid), 32'd0); chk("flush_wait", 32'(bus.mem_waiting), 32'd1); post();
      end
      idle(); resp(32'hCAFE_F00D);
      pre(); chk("flush_4th_v", 32'(bus.out_valid), 32'd1); chk("flush_4th_d", bus.out_rf_wdata, 32'hCAFE_F00D); post();

      // Reset with loads pending and a nonzero discard count
      idle(); set_push(32'h700, LD_W, 32'h0, 1'b1, 1'b1, 1'b0); cycle();
      idle(); set_push(32'h704, LD_W, 32'h0, 1'b1, 1'b1, 1'b0); bus.flush = 1'b1; cycle();
      idle(); set_push(32'h708, LD_W, 32'h0, 1'b1, 1'b1, 1'b0); cycle();
      idle(); set_push(32'h70C, LD_W, 32'h0, 1'b1, 1'b1, 1'b0); cycle();
      idle();
      reset = 1'b1;
      #1;
      mq.delete();
      disc = 0;
      chk("arst_count",   32'(bus.count),       32'd0);
      chk("arst_ov",      32'(bus.out_valid),   32'd0);
      chk("arst_waiting", 32'(bus.mem_waiting), 32'd0);
      chk("arst_allowin", 32'(bus.in_allowin),  32'd1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(); set_push(32'h800, LD_W, 32'h0, 1'b1, 1'b1, 1'b0); cycle();
      idle(); resp(32'h600D_BEEF);
      pre(); chk("arst_disc_v", 32'(bus.out_valid), 32'd1); chk("arst_disc_d", bus.out_rf_wdata, 32'h600D_BEEF); post();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int outst;
         outst = disc;
         foreach (mq[i]) if (mq[i].req && !mq[i].done) outst++;
         idle();
         bus.out_allowin = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 1) == 1)
            set_push($urandom, 5'(1 << $urandom_range(0, 4)), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0));
         if (outst > 0 && $urandom_range(0, 1) == 1) resp($urandom);
         if (disc < 8 && $urandom_range(0, 24) == 0) bus.flush = 1'b1;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
